// File: rtl/rom_loader_pkg.sv
// Shared definitions for the boot loader and instruction ROM.
// Holds loader state encodings, ROM geometry and frame helpers.
package rom_loader_pkg;

  localparam int ROM_ADDR_W = 15;
  localparam int WORD_W     = 16;

  typedef enum logic [2:0] {
    S_CNT_HI = 3'd0,
    S_CNT_LO = 3'd1,
    S_DAT_HI = 3'd2,
    S_DAT_LO = 3'd3,
    S_CSUM   = 3'd4,
    S_RUN    = 3'd5,
    S_ERR    = 3'd6
  } loadState_t;

  // States in which the loader is consuming frame bytes.
  function automatic logic isLoading(input loadState_t s);
    return (s != S_RUN) && (s != S_ERR);
  endfunction

endpackage

// File: rtl/rom_dp.sv
// Instruction ROM storage: 2**ADDR_W x WORD_W words.
// Ports: clk, we/wAddr/wData (sync write), rAddr/rData (async read).
module rom_dp
  import rom_loader_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [WORD_W-1:0] wData,
  input  logic [ADDR_W-1:0] rAddr,
  output logic [WORD_W-1:0] rData
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wAddr] <= wData;
    end
  end

  assign rData = mem[rAddr];

endmodule

// File: rtl/rom_loader.sv
// Boot loader + instruction ROM in front of the cpu.
// Ports: clk, reset, rx_valid/rx_data/rx_ready (byte stream), reload,
//   pc -> instruction, cpu_reset, loaded, error.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        reload,
  input  logic [15:0] pc,
  output logic [15:0] instruction,
  output logic        cpu_reset,
  output logic        loaded,
  output logic        error
);

  localparam int DEPTH = 2 ** ADDR_W;

  loadState_t state;
  loadState_t stateNext;

  logic [15:0]       cnt;
  logic [ADDR_W-1:0] wrAddr;
  logic [7:0]        hiByte;
  logic [7:0]        csum;

  logic        accept;
  logic        clr;
  logic [15:0] hdr;
  logic        hdrTooBig;
  logic        lastWord;
  logic        romWe;
  logic [15:0] romData;
  logic        inRange;

  assign rx_ready  = isLoading(state);
  assign accept    = rx_valid && rx_ready;
  assign hdr       = {hiByte, rx_data};
  assign hdrTooBig = {16'h0, hdr} > 32'(DEPTH);
  assign lastWord  = (32'(wrAddr) + 32'd1) == {16'h0, cnt};

  // Clearing on reload shares the reset path so both restart identically.
  assign clr = reset || ((state == S_RUN) && reload);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_CNT_HI;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      S_CNT_HI: begin
        if (accept) stateNext = S_CNT_LO;
      end
      S_CNT_LO: begin
        if (accept) begin
          if (hdrTooBig)
            stateNext = S_ERR;
          else if (hdr == 16'h0)
            stateNext = S_CSUM;
          else
            stateNext = S_DAT_HI;
        end
      end
      S_DAT_HI: begin
        if (accept) stateNext = S_DAT_LO;
      end
      S_DAT_LO: begin
        if (accept)
          stateNext = lastWord ? S_CSUM : S_DAT_HI;
      end
      S_CSUM: begin
        if (accept)
          stateNext = (rx_data == csum) ? S_RUN : S_ERR;
      end
      S_RUN: begin
        if (reload) stateNext = S_CNT_HI;
      end
      S_ERR: begin
        stateNext = S_ERR;
      end
      default: begin
        stateNext = S_CNT_HI;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt    <= '0;
      wrAddr <= '0;
      hiByte <= '0;
      csum   <= '0;
    end else if (accept) begin
      csum <= csum ^ rx_data;
      unique case (state)
        S_CNT_HI: hiByte <= rx_data;
        S_CNT_LO: begin
          // Oversize header leaves N at 0 so nothing becomes visible.
          if (!hdrTooBig) cnt <= hdr;
        end
        S_DAT_HI: hiByte <= rx_data;
        S_DAT_LO: wrAddr <= wrAddr + 1'b1;
        default: ;
      endcase
    end
  end

  assign romWe = accept && (state == S_DAT_LO);

  rom_dp #(
    .ADDR_W(ADDR_W)
  ) u_rom (
    .clk  (clk),
    .we   (romWe),
    .wAddr(wrAddr),
    .wData({hiByte, rx_data}),
    .rAddr(pc[ADDR_W-1:0]),
    .rData(romData)
  );

  // N hides stale words left over from earlier, longer programs.
  assign inRange = ({16'h0, pc} < {16'h0, cnt})
                && ({16'h0, pc} < 32'(DEPTH));

  assign instruction = inRange ? romData : 16'h0000;
  assign cpu_reset   = (state != S_RUN);
  assign loaded      = (state == S_RUN);
  assign error       = (state == S_ERR);

endmodule

// File: tb/tb_rom_loader.sv
// Testbench for rom_loader: directed frames plus randomized frames
// checked against a word-array model of the loaded program.
module tb_rom_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        rxValid, reload;
  logic [7:0]  rxData;
  logic        rxReady, cpuReset, loaded, error;
  logic [15:0] pc, instr;

  logic        sValid, sReload;
  logic [7:0]  sData;
  logic        sReady, sCpuReset, sLoaded, sError;
  logic [15:0] sPc, sInstr;

  rom_loader dut (
    .clk(clk), .reset(reset),
    .rx_valid(rxValid), .rx_data(rxData), .rx_ready(rxReady),
    .reload(reload), .pc(pc), .instruction(instr),
    .cpu_reset(cpuReset), .loaded(loaded), .error(error)
  );

  rom_loader #(.ADDR_W(4)) dutS (
    .clk(clk), .reset(reset),
    .rx_valid(sValid), .rx_data(sData), .rx_ready(sReady),
    .reload(sReload), .pc(sPc), .instruction(sInstr),
    .cpu_reset(sCpuReset), .loaded(sLoaded), .error(sError)
  );

  int nTests = 0;
  int nFail  = 0;
  int sStrobes = 0;

  always @(posedge clk) if (dutS.romWe) sStrobes++;

  logic [15:0] mRom [32768];
  int          mN = 0;
  logic [15:0] words[$];
  logic [7:0]  frame[$];

  function automatic logic [15:0] expInstr(input logic [15:0] p);
    if (int'(p) < mN && int'(p) < 32768) return mRom[p[14:0]];
    return 16'h0000;
  endfunction

  task automatic buildFrame(input bit bad);
    logic [7:0] x;
    frame.delete();
    frame.push_back(8'(words.size() >> 8));
    frame.push_back(8'(words.size()));
    foreach (words[i]) begin
      frame.push_back(words[i][15:8]);
      frame.push_back(words[i][7:0]);
    end
    x = 8'h00;
    foreach (frame[i]) x = x ^ frame[i];
    if (bad) x = x ^ (8'h01 << $urandom_range(0, 7));
    frame.push_back(x);
  endtask

  task automatic doReset();
    reset = 1'b1; rxValid = 1'b0; sValid = 1'b0;
    reload = 1'b0; sReload = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    mN = 0;
  endtask

  task automatic pulseReload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    rxValid = 1'b1; rxData = b;
    nTests++;
    if (rxReady !== 1'b1) begin
      nFail++;
      $display("FAIL rxReady byte=%h got %b want 1", b, rxReady);
    end
    @(negedge clk);
    rxValid = 1'b0; rxData = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic sendByteS(input logic [7:0] b);
    sValid = 1'b1; sData = b;
    @(negedge clk);
    sValid = 1'b0;
  endtask

  task automatic sendFrame(input int gapMax);
    foreach (frame[i]) sendByte(frame[i], $urandom_range(0, gapMax));
  endtask

  task automatic test_reset();
    doReset();
    pc = 16'h0000; #1;
    nTests++;
    if ({rxReady, cpuReset, loaded, error, instr} !== {4'b1100, 16'h0}) begin
      nFail++;
      $display("FAIL reset got rdy=%b crst=%b ld=%b err=%b ins=%h want 1 1 0 0 0000",
               rxReady, cpuReset, loaded, error, instr);
    end
  endtask

  task automatic test_basic();
    logic [7:0]  bs [7];
    logic [15:0] exp [3];
    bs = '{8'h00, 8'h02, 8'h30, 8'h39, 8'hEC, 8'h10, 8'hF7};
    exp = '{16'h3039, 16'hEC10, 16'h0000};
    for (int i = 0; i < 6; i++) sendByte(bs[i], 0);
    nTests++;
    if (cpuReset !== 1'b1) begin
      nFail++; $display("FAIL basicPreCsum cpuReset got %b want 1", cpuReset);
    end
    sendByte(bs[6], 0);
    nTests++;
    if ({cpuReset, loaded, rxReady, error} !== 4'b0100) begin
      nFail++;
      $display("FAIL basicDone got crst=%b ld=%b rdy=%b err=%b want 0 1 0 0",
               cpuReset, loaded, rxReady, error);
    end
    mRom[0] = 16'h3039; mRom[1] = 16'hEC10; mN = 2;
    for (int p = 0; p < 3; p++) begin
      pc = 16'(p); #1;
      nTests++;
      if (instr !== exp[p]) begin
        nFail++; $display("FAIL basicPc pc=%0d got %h want %h", p, instr, exp[p]);
      end
    end
  endtask

  task automatic test_bad_csum();
    logic [7:0] bs [7];
    bs = '{8'h00, 8'h02, 8'h30, 8'h39, 8'hEC, 8'h10, 8'hF6};
    doReset();
    for (int i = 0; i < 7; i++) sendByte(bs[i], 0);
    pulseReload();
    repeat (2) @(negedge clk);
    nTests++;
    if ({error, cpuReset, rxReady, loaded} !== 4'b1100) begin
      nFail++;
      $display("FAIL badCsum got err=%b crst=%b rdy=%b ld=%b want 1 1 0 0",
               error, cpuReset, rxReady, loaded);
    end
    doReset();
    pc = 16'h0000; #1;
    nTests++;
    if ({error, rxReady, instr} !== {2'b01, 16'h0}) begin
      nFail++;
      $display("FAIL badCsumReset got err=%b rdy=%b ins=%h want 0 1 0000",
               error, rxReady, instr);
    end
  endtask

  task automatic test_oversize();
    logic [15:0] sw [16];
    logic [7:0]  x;
    logic [15:0] e;
    doReset();
    sStrobes = 0;
    sendByteS(8'h00);
    sendByteS(8'h11);
    nTests++;
    if ({sError, sReady, sLoaded} !== 3'b100 || sStrobes != 0) begin
      nFail++;
      $display("FAIL oversize got err=%b rdy=%b ld=%b strobes=%0d want 1 0 0 0",
               sError, sReady, sLoaded, sStrobes);
    end
    doReset();
    x = 8'h00 ^ 8'h10;
    sendByteS(8'h00); sendByteS(8'h10);
    for (int i = 0; i < 16; i++) begin
      sw[i] = 16'($urandom);
      x = x ^ sw[i][15:8] ^ sw[i][7:0];
      sendByteS(sw[i][15:8]); sendByteS(sw[i][7:0]);
    end
    sendByteS(x);
    nTests++;
    if ({sLoaded, sError} !== 2'b10 || sStrobes != 16) begin
      nFail++;
      $display("FAIL fullDepth got ld=%b err=%b strobes=%0d want 1 0 16",
               sLoaded, sError, sStrobes);
    end
    for (int p = 0; p < 19; p++) begin
      sPc = (p == 18) ? 16'hFFFF : 16'(p); #1;
      e = (p < 16) ? sw[p] : 16'h0000;
      nTests++;
      if (sInstr !== e) begin
        nFail++; $display("FAIL fullDepthPc pc=%h got %h want %h", sPc, sInstr, e);
      end
    end
  endtask

  task automatic test_empty();
    doReset();
    sendByte(8'h00, 0); sendByte(8'h00, 0); sendByte(8'h00, 0);
    nTests++;
    if ({loaded, cpuReset} !== 2'b10) begin
      nFail++; $display("FAIL emptyLoad got ld=%b crst=%b want 1 0", loaded, cpuReset);
    end
    for (int i = 0; i < 6; i++) begin
      pc = (i == 0) ? 16'h0000 : 16'($urandom); #1;
      nTests++;
      if (instr !== 16'h0000) begin
        nFail++; $display("FAIL emptyPc pc=%h got %h want 0000", pc, instr);
      end
    end
    @(negedge clk);
    pulseReload();
    nTests++;
    if ({cpuReset, rxReady, loaded} !== 3'b110) begin
      nFail++;
      $display("FAIL emptyReload got crst=%b rdy=%b ld=%b want 1 1 0",
               cpuReset, rxReady, loaded);
    end
  endtask

  task automatic test_stall();
    logic [7:0] bs [7];
    bs = '{8'h00, 8'h02, 8'h30, 8'h39, 8'hEC, 8'h10, 8'hF7};
    for (int i = 0; i < 7; i++) begin
      sendByte(bs[i], 3);
      if (i == 1) pulseReload();
    end
    mRom[0] = 16'h3039; mRom[1] = 16'hEC10; mN = 2;
    for (int p = 0; p < 3; p++) begin
      pc = 16'(p); #1;
      nTests++;
      if (instr !== expInstr(pc) || loaded !== 1'b1) begin
        nFail++;
        $display("FAIL stallPc pc=%0d got %h ld=%b want %h 1", p, instr, loaded, expInstr(pc));
      end
    end
    @(negedge clk);
    pulseReload();
    for (int i = 0; i < 4; i++) sendByte(bs[i], 3);
    doReset();
    for (int p = 0; p < 3; p++) begin
      pc = 16'(p); #1;
      nTests++;
      if (instr !== 16'h0000 || rxReady !== 1'b1) begin
        nFail++;
        $display("FAIL midResetPc pc=%0d got %h rdy=%b want 0000 1", p, instr, rxReady);
      end
    end
    @(negedge clk);
    words = '{16'h1234, 16'hABCD, 16'h0055};
    buildFrame(1'b0);
    sendFrame(3);
    foreach (words[i]) mRom[i] = words[i];
    mN = 3;
    for (int p = 0; p < 4; p++) begin
      pc = 16'(p); #1;
      nTests++;
      if (instr !== expInstr(pc) || loaded !== 1'b1) begin
        nFail++;
        $display("FAIL reloadAfterReset pc=%0d got %h want %h", p, instr, expInstr(pc));
      end
    end
  endtask

  task automatic test_stale();
    @(negedge clk);
    pulseReload();
    mN = 0;
    words = '{16'($urandom), 16'($urandom), 16'($urandom)};
    buildFrame(1'b0);
    sendFrame(1);
    foreach (words[i]) mRom[i] = words[i];
    mN = 3;
    pulseReload();
    mN = 0;
    words = '{16'h03E8};
    buildFrame(1'b0);
    nTests++;
    if (frame[4] !== 8'hEA) begin
      nFail++; $display("FAIL staleCsumByte got %h want EA", frame[4]);
    end
    sendFrame(0);
    mRom[0] = 16'h03E8; mN = 1;
    for (int p = 0; p < 3; p++) begin
      pc = 16'(p); #1;
      nTests++;
      if (instr !== ((p == 0) ? 16'h03E8 : 16'h0000)) begin
        nFail++; $display("FAIL stalePc pc=%0d got %h want %h", p, instr, expInstr(pc));
      end
    end
  endtask

  task automatic test_random();
    int  n;
    bit  bad;
    for (int it = 0; it < 12; it++) begin
      @(negedge clk);
      if (loaded === 1'b1) begin
        pulseReload();
        mN = 0;
      end else begin
        doReset();
      end
      n = $urandom_range(1, 12);
      bad = ($urandom_range(0, 3) == 0);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back(16'($urandom));
      buildFrame(bad);
      sendFrame(2);
      foreach (words[i]) mRom[i] = words[i];
      if (bad) begin
        nTests++;
        if ({error, loaded, cpuReset} !== 3'b101) begin
          nFail++;
          $display("FAIL randBad it=%0d got err=%b ld=%b crst=%b want 1 0 1",
                   it, error, loaded, cpuReset);
        end
      end else begin
        mN = n;
        nTests++;
        if ({loaded, error, cpuReset} !== 3'b100) begin
          nFail++;
          $display("FAIL randLoad it=%0d got ld=%b err=%b crst=%b want 1 0 0",
                   it, loaded, error, cpuReset);
        end
        for (int k = 0; k < n + 6; k++) begin
          pc = (k < n + 2) ? 16'(k) : 16'($urandom_range(0, 20));
          #1;
          nTests++;
          if (instr !== expInstr(pc)) begin
            nFail++;
            $display("FAIL randPc it=%0d pc=%h got %h want %h", it, pc, instr, expInstr(pc));
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; rxValid = 1'b0; rxData = 8'h00; reload = 1'b0;
    sValid = 1'b0; sData = 8'h00; sReload = 1'b0;
    pc = 16'h0000; sPc = 16'h0000;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_bad_csum();
    test_oversize();
    test_empty();
    test_stall();
    test_stale();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
